serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
- Bit-serial unsigned magnitude comparator for two WIDTH-bit operands presented one bit pair per cycle, MSB first.
- Uses the existing 1-bit comparator cell per bit and a decision FSM to produce sticky greater/equal/less flags.
- Acts as the sequential consumer of 1-bit compare results, behind serial links where parallel operands are not available.

Parameters:
WIDTH, 8, operand width in bits (legal range 1..64).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin new compare; accepted only in IDLE or DONE.
bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
a_bit  input  1  operand A bit, MSB first.
b_bit  input  1  operand B bit, MSB first.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse when the result becomes valid.
o1  output  1  A>B, held until next start.
o2  output  1  A==B, held until next start.
o3  output  1  A<B, held until next start.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; busy=0, done=0, o1=0, o2=0, o3=0; bit counter=0; decided flag=0.
- States:
  - IDLE: start -> SHIFT; counter=0, decided=0, o1/o2/o3 cleared.
  - SHIFT: on each bit_valid cycle, counter+1. If not yet decided, feed the bit pair to comparator_1bit.
    - Cell reports gt: latch o1 result, decided=1.
    - Cell reports lt: latch o3 result, decided=1.
    - Cell reports eq: no latch.
    - On the WIDTH-th valid bit (counter==WIDTH-1 before increment): go to DONE.
  - DONE: done=1 for exactly the entry cycle; o1/o2/o3 visible (one-hot) from that same cycle. If still undecided, o2=1. Stay in DONE until start.
- Invalid cycles: bit_valid=0 in SHIFT stalls, with no counter change and no decision change.
- Once decided, later bits are counted but ignored; the first differing bit (MSB-most) wins.
- Latency: done asserts the cycle after the final valid bit is sampled.
- Simultaneous start and bit_valid in IDLE/DONE: start wins and that bit is discarded. The first bit is sampled the cycle after start.
- start during SHIFT is ignored; there is no abort except reset.
- Reset mid-SHIFT: immediate return to IDLE, with all outputs zero.
- Counter width: $clog2(WIDTH+1). WIDTH=1 must work with a single bit.
- Invariant: o1+o2+o3 is 0 outside DONE-valid and exactly 1 once done has pulsed.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: SHIFT -> DONE on the first differing bit (done pulses the next cycle). Remaining bits of that operand must not be sent; the upstream sees busy fall.
- Undefined: all WIDTH bits are always consumed, giving fixed latency as specified above.

Decomposition:
- Package serial_cmp_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Result index constants GT=0, EQ=1, LT=2.
  - Function cnt_w(WIDTH) returning the counter width.
- Sub-module: comparator_1bit (existing A/B -> o1/o2/o3 cell), instantiated once for the per-bit decision. No other sub-modules.

Test Plan:
- WIDTH=8, A=0xA5, B=0xA5, bit_valid every cycle after start -> done 9 cycles after start, o2=1, o1=o3=0.
- A=0x80, B=0x7F -> o1=1 at done. With EARLY_EXIT_EN, done pulses 2 cycles after start and busy drops after the first bit.
- A=0x12, B=0x13, with bit_valid gapped (1 every 3 cycles) -> o3=1, done only after the 8th valid bit, counter frozen during gaps.
- rst_n pulsed low after 4 bits of A=0xFF/B=0x00 -> all outputs 0 immediately. A new start with A=0x00/B=0x00 gives o2=1.
- WIDTH=1 sweep of all four (a,b) pairs -> o1/o2/o3 match the 1-bit truth table, done one cycle after the bit.
- start asserted during SHIFT, and start coincident with bit_valid in DONE -> the SHIFT start is ignored; the DONE case restarts with that bit discarded and the result cleared.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
//   state_t      : decision FSM states (IDLE, SHIFT, DONE)
//   GT / EQ / LT : bit positions of the one-hot result vector
//   cnt_w()      : width of a counter that must hold 0..WIDTH
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int GT = 0;
  localparam int EQ = 1;
  localparam int LT = 2;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/comparator_1bit.sv
// Single-bit unsigned comparator cell.
// Ports:
//   a, b : operand bits
//   o1   : a > b
//   o2   : a == b
//   o3   : a < b
module comparator_1bit (
  input  logic a,
  input  logic b,
  output logic o1,
  output logic o2,
  output logic o3
);

  assign o1 = a & ~b;
  assign o2 = ~(a ^ b);
  assign o3 = ~a & b;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator. Two WIDTH-bit operands arrive
// one bit pair per valid cycle, MSB first; the first differing bit decides
// the result, which is held as sticky one-hot flags until the next start.
//
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN
//   defined   : finish on the first differing bit (variable latency)
//   undefined : always consume all WIDTH bits (fixed latency)
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : begin a new compare (honoured in IDLE or DONE only)
//   bit_valid : a_bit/b_bit carry a valid pair this cycle
//   a_bit     : operand A bit, MSB first
//   b_bit     : operand B bit, MSB first
//   busy      : high while bits are being consumed
//   done      : one-cycle pulse when the result becomes valid
//   o1/o2/o3  : A>B / A==B / A<B, valid from done until the next start
//
// state | meaning
// IDLE  | after reset, waiting for start, all flags low
// SHIFT | consuming bit pairs, busy high
// DONE  | result valid and held, waiting for start
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic o1,
  output logic o2,
  output logic o3
);

  localparam int CW = cnt_w(WIDTH);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          decided, decided_next;
  logic          res_gt, res_gt_next;
  logic          res_lt, res_lt_next;
  logic          done_q, done_next;

  logic          cell_gt, cell_eq, cell_lt;
  logic          last_bit;
  logic [2:0]    result;

  comparator_1bit u_cell (
    .a  (a_bit),
    .b  (b_bit),
    .o1 (cell_gt),
    .o2 (cell_eq),
    .o3 (cell_lt)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      decided <= 1'b0;
      res_gt  <= 1'b0;
      res_lt  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      decided <= decided_next;
      res_gt  <= res_gt_next;
      res_lt  <= res_lt_next;
      done_q  <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    decided_next = decided;
    res_gt_next  = res_gt;
    res_lt_next  = res_lt;
    done_next    = 1'b0;

    case (state)
      IDLE, DONE: begin
        // A bit presented together with start is deliberately dropped.
        if (start) begin
          state_next   = SHIFT;
          cnt_next     = '0;
          decided_next = 1'b0;
          res_gt_next  = 1'b0;
          res_lt_next  = 1'b0;
        end
      end

      SHIFT: begin
        if (bit_valid) begin
          cnt_next = cnt + CW'(1);
          // Only the MSB-most differing bit may set the decision.
          if (!decided && !cell_eq) begin
            decided_next = 1'b1;
            res_gt_next  = cell_gt;
            res_lt_next  = cell_lt;
          end
          if (last_bit) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          else if (!decided && !cell_eq) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
`endif
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Flags are exposed only in DONE, so they stay one-hot there and zero elsewhere.
  always_comb begin
    result     = '0;
    result[GT] = (state == DONE) & res_gt;
    result[LT] = (state == DONE) & res_lt;
    result[EQ] = (state == DONE) & ~decided;
  end

  assign busy = (state == SHIFT);
  assign done = done_q;
  assign o1   = result[GT];
  assign o2   = result[EQ];
  assign o3   = result[LT];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (WIDTH=8 and WIDTH=1 instances).
// Observed vectors are packed as {busy, done, o1, o2, o3}.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
  logic busy, done, o1, o2, o3;

  logic start1 = 1'b0, valid1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic busy1, done1, o1_1, o2_1, o3_1;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0] obs8, obs1;
  assign obs8 = {busy, done, o1, o2, o3};
  assign obs1 = {busy1, done1, o1_1, o2_1, o3_1};

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
    .o1(o1), .o2(o2), .o3(o3)
  );

  serial_magnitude_comparator #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bit_valid(valid1),
    .a_bit(a1), .b_bit(b1), .busy(busy1), .done(done1),
    .o1(o1_1), .o2(o2_1), .o3(o3_1)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One full 8-bit compare. gap: idle cycles before each valid bit.
  // start_at: bit index at which start is also raised (ignored in SHIFT).
  // junk: raise bit_valid with start (that pair must be discarded).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int gap,
                      input int start_at, input bit junk);
    start = 1'b1;
    bit_valid = junk;
    a_bit = 1'b1;
    b_bit = 1'b0;
    @(negedge clk);
    start = 1'b0;
    bit_valid = 1'b0;
    chk("shift_entry", obs8, 5'b10000);
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        bit_valid = 1'b0;
        @(negedge clk);
        chk("gap_stall", obs8, 5'b10000);
      end
      bit_valid = 1'b1;
      a_bit = a[i];
      b_bit = b[i];
      start = (i == start_at);
      @(negedge clk);
      start = 1'b0;
      if (i > 0) chk("mid_busy", obs8, 5'b10000);
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp1 [4];
    logic [1:0] ab;
    exp1[0] = 5'b01010;  // a=0 b=0
    exp1[1] = 5'b01001;  // a=0 b=1
    exp1[2] = 5'b01100;  // a=1 b=0
    exp1[3] = 5'b01010;  // a=1 b=1

    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("reset8", obs8, 5'b00000);
    chk("reset1", obs1, 5'b00000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle8", obs8, 5'b00000);

    // Equal operands
    run8(8'hA5, 8'hA5, 0, -1, 1'b0);
    chk("a5_eq_done", obs8, 5'b01010);
    @(negedge clk);
    chk("a5_eq_hold", obs8, 5'b00010);

    // MSB differs
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("80_shift_entry", obs8, 5'b10000);
    bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    @(negedge clk);
    bit_valid = 1'b0;
    chk("80_early_done", obs8, 5'b01100);
`else
    run8(8'h80, 8'h7F, 0, -1, 1'b0);
    chk("80_gt_done", obs8, 5'b01100);
`endif
    @(negedge clk);
    chk("80_gt_hold", obs8, 5'b00100);

    // Gapped input, LSB decides
    run8(8'h12, 8'h13, 2, -1, 1'b0);
    chk("12_lt_done", obs8, 5'b01001);
    @(negedge clk);
    chk("12_lt_hold", obs8, 5'b00001);

    // Reset in the middle of a compare
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      @(negedge clk);
    end
    bit_valid = 1'b0;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    chk("ff_before_rst", obs8, 5'b00100);
`else
    chk("ff_before_rst", obs8, 5'b10000);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_reset_async", obs8, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", obs8, 5'b00000);
    run8(8'h00, 8'h00, 0, -1, 1'b0);
    chk("00_eq_done", obs8, 5'b01010);

    // start during SHIFT must be ignored
    run8(8'h01, 8'h00, 0, 4, 1'b0);
    chk("shift_start_ignored", obs8, 5'b01100);

    // start with a bit in DONE: restart, bit discarded, result cleared
    run8(8'h00, 8'h00, 0, -1, 1'b1);
    chk("done_restart_eq", obs8, 5'b01010);

    // WIDTH=1 truth table
    for (int k = 0; k < 4; k++) begin
      ab = 2'(k);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_busy", obs1, 5'b10000);
      valid1 = 1'b1; a1 = ab[1]; b1 = ab[0];
      @(negedge clk);
      valid1 = 1'b0;
      chk("w1_result", obs1, exp1[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
